// File: rtl/regfile_dump_pkg.sv
// Shared register-file constants and the regfile_dump FSM state encoding.
// Optional feature macro used by regfile_dump: REGFILE_DUMP_CHECKSUM_EN.
package regfile_dump_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_READ = 3'd1;
   localparam state_t ST_SEND = 3'd2;
   localparam state_t ST_SUM  = 3'd3;
   localparam state_t ST_FIN  = 3'd4;

endpackage

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks the register file read port and streams each word over valid/ready.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned DATA_W   = REG_DATA_W
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] RA,
   input  logic [DATA_W-1:0] RD,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [ADDR_W-1:0] OutIdx,
   output logic [DATA_W-1:0] OutData,
   output logic              OutLast
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_next;
   logic              is_last;
   logic              handshake;

   assign idx_next  = idx + ADDR_W'(1);
   assign is_last   = (idx == LAST_IDX);
   assign handshake = OutValid && OutReady;

`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         checksum <= '0;
      end else if (state == ST_IDLE && Start) begin
         checksum <= '0;
      end else if (state == ST_READ) begin
         checksum <= checksum ^ RD;
      end
   end
`endif

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state    <= ST_IDLE;
         idx      <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         RA       <= '0;
         OutValid <= 1'b0;
         OutIdx   <= '0;
         OutData  <= '0;
         OutLast  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  state <= ST_READ;
                  idx   <= '0;
                  RA    <= '0;
                  Busy  <= 1'b1;
               end
            end

            // RD is sampled here, so a write landing earlier in this cycle is captured.
            ST_READ: begin
               OutData  <= RD;
               OutIdx   <= idx;
               OutValid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
               OutLast  <= 1'b0;
`else
               OutLast  <= is_last;
`endif
               state    <= ST_SEND;
            end

            ST_SEND: begin
               if (handshake) begin
                  OutValid <= 1'b0;
                  if (is_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                     OutValid <= 1'b1;
                     OutData  <= checksum;
                     OutIdx   <= '0;
                     OutLast  <= 1'b1;
                     state    <= ST_SUM;
`else
                     Done  <= 1'b1;
                     Busy  <= 1'b0;
                     RA    <= '0;
                     state <= ST_FIN;
`endif
                  end else begin
                     idx   <= idx_next;
                     RA    <= idx_next;
                     state <= ST_READ;
                  end
               end
            end

            ST_SUM: begin
               if (handshake) begin
                  OutValid <= 1'b0;
                  Done     <= 1'b1;
                  Busy     <= 1'b0;
                  RA       <= '0;
                  state    <= ST_FIN;
               end
            end

            // Done is raised on entry so it is visible for exactly the FIN cycle.
            ST_FIN: begin
               Done  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
